// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller and its busy counter.
package hazard_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 4;
  // Wide enough for the largest legal MD_LATENCY-1 (14).
  localparam int         MD_CNT_W       = 4;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle of the hazard/stall controller.
interface hazard_stall_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_UsesHiLo;
  logic             ID_MulStart;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] ID_EX_Rt;
  logic             BranchTaken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             nop;
  logic             HiLoBusy;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_MulStart,
           ID_EX_MemRead, ID_EX_Rt, BranchTaken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, nop, HiLoBusy, StallCycles
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_MulStart,
           ID_EX_MemRead, ID_EX_Rt, BranchTaken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, nop, HiLoBusy, StallCycles
  );

endinterface

// File: rtl/hazard_stall_controller_md_busy_counter.sv
// Loadable down-counter tracking how long a mult/div still owns Hi/Lo.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int W = MD_CNT_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = load_val;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Busy drops on the edge where the count has already reached zero.
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign last = busy_q & (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / Hi-Lo stall and branch-squash sequencing for the MIPS pipeline,
// with a saturating stall-cycle counter.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input logic                      Clk,
  input logic                      Rst,
  hazard_stall_controller_if.slave hz
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_haz;
  logic hilo_haz;
  logic stall;
  logic md_issue;
  logic md_busy;
  logic md_last;

  // A load into $0 never produces a value, so it cannot create a hazard.
  assign load_haz = hz.ID_EX_MemRead
                  & (hz.ID_EX_Rt != REG_W'(REG_ZERO))
                  & ((hz.ID_UsesRs & (hz.IF_ID_Rs == hz.ID_EX_Rt))
                   | (hz.ID_UsesRt & (hz.IF_ID_Rt == hz.ID_EX_Rt)));

  assign hilo_haz = (state_q == MD_BUSY) & hz.ID_UsesHiLo;
  assign stall    = (load_haz | hilo_haz) & ~hz.BranchTaken;
  assign md_issue = (state_q == IDLE) & hz.ID_MulStart & ~stall & ~hz.BranchTaken;

  md_busy_counter #(
    .W (MD_CNT_W)
  ) u_md_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (md_issue),
    .load_val (MD_CNT_W'(MD_LATENCY - 1)),
    .busy     (md_busy),
    .last     (md_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_issue) state_d = MD_BUSY;
      MD_BUSY: if (md_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Branch squash outranks any stall; everything is held low during reset.
  always_comb begin
    hz.PCWrite     = 1'b0;
    hz.IF_ID_Write = 1'b0;
    hz.IF_ID_Flush = 1'b0;
    hz.nop         = 1'b0;
    if (Rst) begin
      if (hz.BranchTaken) begin
        hz.PCWrite     = 1'b1;
        hz.IF_ID_Write = 1'b1;
        hz.IF_ID_Flush = 1'b1;
      end else if (!stall) begin
        hz.PCWrite     = 1'b1;
        hz.IF_ID_Write = 1'b1;
        hz.nop         = 1'b1;
      end
    end
  end

  assign hz.HiLoBusy    = Rst & md_busy;
  assign hz.StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench: two controller instances (default and saturation config).
module tb_hazard_stall_controller;

  typedef struct {
    string       nm;
    logic [4:0]  flg;   // {PCWrite, IF_ID_Write, IF_ID_Flush, nop, HiLoBusy}
    logic [15:0] cnt;
  } exp_t;

  logic Clk;
  logic Rst;

  exp_t q1[$];
  exp_t q2[$];
  int   vectors;
  int   miscompares;
  int   sat;

  hazard_stall_controller_if #(.REG_W(5), .CNT_W(16)) if1 ();
  hazard_stall_controller_if #(.REG_W(5), .CNT_W(4))  if2 ();

  hazard_stall_controller #(.MD_LATENCY(4), .REG_W(5), .CNT_W(16)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (if1.slave)
  );

  hazard_stall_controller #(.MD_LATENCY(15), .REG_W(5), .CNT_W(4)) dut2 (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (if2.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clr1();
    if1.IF_ID_Rs = '0; if1.IF_ID_Rt = '0; if1.ID_UsesRs = 0; if1.ID_UsesRt = 0;
    if1.ID_UsesHiLo = 0; if1.ID_MulStart = 0; if1.ID_EX_MemRead = 0;
    if1.ID_EX_Rt = '0; if1.BranchTaken = 0;
  endtask

  task automatic clr2();
    if2.IF_ID_Rs = '0; if2.IF_ID_Rt = '0; if2.ID_UsesRs = 0; if2.ID_UsesRt = 0;
    if2.ID_UsesHiLo = 0; if2.ID_MulStart = 0; if2.ID_EX_MemRead = 0;
    if2.ID_EX_Rt = '0; if2.BranchTaken = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic exp1(input string nm, input logic [4:0] flg, input int cnt);
    exp_t e;
    e.nm = nm; e.flg = flg; e.cnt = 16'(cnt);
    q1.push_back(e);
  endtask

  task automatic exp2(input string nm, input logic [4:0] flg, input int cnt);
    exp_t e;
    e.nm = nm; e.flg = flg; e.cnt = 16'(cnt);
    q2.push_back(e);
  endtask

  // Monitor: checks the outputs mid-cycle, after the inputs of that cycle settled.
  always @(negedge Clk) begin
    exp_t e;
    logic [4:0] got;
    if (q1.size() > 0) begin
      e   = q1.pop_front();
      got = {if1.PCWrite, if1.IF_ID_Write, if1.IF_ID_Flush, if1.nop, if1.HiLoBusy};
      vectors++;
      if (got !== e.flg || 16'(if1.StallCycles) !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                 e.nm, got, if1.StallCycles, e.flg, e.cnt);
      end
    end
    if (q2.size() > 0) begin
      e   = q2.pop_front();
      got = {if2.PCWrite, if2.IF_ID_Write, if2.IF_ID_Flush, if2.nop, if2.HiLoBusy};
      vectors++;
      if (got !== e.flg || 16'(if2.StallCycles) !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                 e.nm, got, if2.StallCycles, e.flg, e.cnt);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    Rst = 1'b0;
    clr1();
    clr2();
    tick();
    tick();
    // Reset with a live load-use hazard on the inputs: everything forced low.
    if1.ID_EX_MemRead = 1; if1.ID_EX_Rt = 5'd8; if1.IF_ID_Rs = 5'd8; if1.ID_UsesRs = 1;
    exp1("reset", 5'b00000, 0);

    tick(); Rst = 1'b1;
    exp1("lu_stall", 5'b00000, 0);
    tick(); if1.ID_EX_MemRead = 0;
    exp1("lu_release", 5'b11010, 1);

    tick(); clr1();
    if1.ID_EX_MemRead = 1; if1.ID_EX_Rt = 5'd0; if1.IF_ID_Rs = 5'd0; if1.IF_ID_Rt = 5'd0;
    if1.ID_UsesRs = 1; if1.ID_UsesRt = 1;
    exp1("lw_r0", 5'b11010, 1);

    tick(); if1.ID_EX_Rt = 5'd9; if1.IF_ID_Rt = 5'd9; if1.IF_ID_Rs = 5'd3; if1.ID_UsesRt = 0;
    exp1("rt_unused", 5'b11010, 1);
    tick(); if1.ID_UsesRt = 1;
    exp1("lu_rt", 5'b00000, 1);
    tick(); clr1();
    exp1("lu_rt_rel", 5'b11010, 2);

    // mult then mflo: four-cycle Hi/Lo stall.
    tick(); if1.ID_MulStart = 1; if1.ID_UsesHiLo = 1;
    exp1("mult_issue", 5'b11010, 2);
    for (int i = 0; i < 4; i++) begin
      tick(); if1.ID_MulStart = 0;
      exp1($sformatf("mflo_stall%0d", i), 5'b00001, 2 + i);
    end
    tick();
    exp1("mflo_go", 5'b11010, 6);

    // Branch beats load-use and squashes the mult issue.
    tick(); clr1();
    if1.ID_EX_MemRead = 1; if1.ID_EX_Rt = 5'd8; if1.IF_ID_Rs = 5'd8; if1.ID_UsesRs = 1;
    if1.ID_MulStart = 1; if1.ID_UsesHiLo = 1; if1.BranchTaken = 1;
    exp1("br_squash", 5'b11100, 6);
    tick(); clr1();
    exp1("br_after", 5'b11010, 6);

    // Branch while a mult is in flight: the busy count keeps running.
    tick(); if1.ID_MulStart = 1; if1.ID_UsesHiLo = 1;
    exp1("mult2_issue", 5'b11010, 6);
    tick(); if1.ID_MulStart = 0; if1.BranchTaken = 1;
    exp1("br_in_md", 5'b11101, 6);
    for (int i = 0; i < 3; i++) begin
      tick(); if1.BranchTaken = 0;
      exp1($sformatf("mflo2_stall%0d", i), 5'b00001, 6 + i);
    end
    tick();
    exp1("mflo2_go", 5'b11010, 9);

    // Reset two cycles into a mult.
    tick(); clr1(); if1.ID_MulStart = 1; if1.ID_UsesHiLo = 1;
    exp1("mult3_issue", 5'b11010, 9);
    tick(); clr1();
    exp1("md_a", 5'b11011, 9);
    tick();
    exp1("md_b", 5'b11011, 9);
    tick(); Rst = 1'b0; if1.ID_UsesHiLo = 1;
    exp1("rst_low0", 5'b00000, 9);
    tick();
    exp1("rst_low1", 5'b00000, 0);
    tick(); Rst = 1'b1;
    exp1("post_rst", 5'b11010, 0);
    tick(); clr1();
    exp1("idle", 5'b11010, 0);

    // Saturation on the 4-bit counter: back-to-back mults, 15-cycle latency.
    tick(); if2.ID_MulStart = 1; if2.ID_UsesHiLo = 1;
    exp2("sat_issue", 5'b11010, 0);
    sat = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 15) begin
        exp2("sat_reissue", 5'b11010, sat);
      end else begin
        exp2($sformatf("sat_stall%0d", i), 5'b00001, sat);
        if (sat < 15) sat++;
      end
    end
    tick(); clr2();
    exp2("sat_hold", 5'b11011, 15);

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    if (q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d unchecked entries, expected 0/0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences pipeline bubbles for the MIPS core.
- Detects load-use hazards, Hi/Lo hazards behind multi-cycle mult/div, and taken-branch squashes.
- Drives PC/IF-ID write enables, the IF/ID flush, and the `nop` select of the ID/EX control-zeroing mux (`nop`=1 passes controls, `nop`=0 inserts a bubble).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, cycles a mult/div occupies Hi/Lo after issue (legal range 2..15)
- REG_W, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- Clk  in  1  clock
- Rst  in  1  reset: synchronous, active-low
- IF_ID_Rs  in  REG_W  rs field of the instruction in ID
- IF_ID_Rt  in  REG_W  rt field of the instruction in ID
- ID_UsesRs  in  1  ID instruction reads rs
- ID_UsesRt  in  1  ID instruction reads rt
- ID_UsesHiLo  in  1  ID instruction reads or writes Hi/Lo (mfhi, mflo, mthi, mtlo, mult, div, madd)
- ID_MulStart  in  1  ID instruction is a multi-cycle mult/div
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rt  in  REG_W  load destination register in EX
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  clear IF/ID to zero
- nop  out  1  to the NOP mux: 1 = pass controls, 0 = bubble
- HiLoBusy  out  1  a mult/div is in flight
- StallCycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (Rst=0 at a Clk edge):
  - State goes to IDLE; the busy counter and StallCycles clear to 0.
  - While Rst=0, outputs are forced: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, nop=0, HiLoBusy=0.
  - Reset asserted mid-MD_BUSY abandons the count; no hazard is held.
- States: IDLE, MD_BUSY. Outputs are combinational from state and inputs. State, counter and StallCycles update on the rising Clk edge.
- LoadHaz = ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_UsesRs & IF_ID_Rs==ID_EX_Rt) | (ID_UsesRt & IF_ID_Rt==ID_EX_Rt)).
- HiLoHaz = (state==MD_BUSY) & ID_UsesHiLo. This includes a second ID_MulStart, which therefore waits.
- Stall = (LoadHaz | HiLoHaz) & ~BranchTaken.
- Priority 1, BranchTaken=1:
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, nop=0.
  - Any pending stall is cancelled.
  - ID_MulStart in the same cycle is squashed and the counter is not loaded.
  - An in-flight MD_BUSY count continues, since that instruction is older and valid.
- Priority 2, Stall=1:
  - PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, nop=0.
  - A load-use stall lasts exactly 1 cycle, because the load advances out of EX.
  - A HiLo stall lasts until the state returns to IDLE.
- Otherwise: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, nop=1.
- IDLE to MD_BUSY: on ID_MulStart & ~Stall & ~BranchTaken, load the counter with MD_LATENCY-1.
- MD_BUSY: the counter decrements each cycle. At counter==0 the state returns to IDLE on that edge. HiLoBusy=1 for exactly MD_LATENCY cycles after the issue edge.
- The ID instruction held stalled by HiLoHaz issues in the first IDLE cycle.
- StallCycles increments on every cycle with Stall=1 and Rst=1. It saturates at all-ones; there is no wrap.
- Writes to $0 never cause a load-use hazard.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum (IDLE, MD_BUSY);
  - REG_ZERO = 5'd0;
  - MD_LATENCY default.
- One natural sub-module, md_busy_counter:
  - loadable down-counter with busy flag;
  - inputs Clk, Rst, load, load_val;
  - output busy.

Test Plan:
1. lw to $8 in EX; ID add reads rs=$8 with UsesRs=1 -> PCWrite=0, IF_ID_Write=0, nop=0 for exactly 1 cycle, then nop=1; StallCycles=1.
2. lw to $0 in EX; ID reads $0 -> no stall, nop=1, StallCycles stays 0.
3. mult issued (MulStart=1), then mflo in ID on the next cycle, MD_LATENCY=4 -> HiLoBusy high 4 cycles; mflo stalled 4 cycles (nop=0), issues on cycle 5 with nop=1; StallCycles=4.
4. BranchTaken=1 coincident with a load-use hazard and MulStart=1 -> IF_ID_Flush=1, PCWrite=1, nop=0, state stays IDLE, StallCycles unchanged.
5. Rst=0 asserted 2 cycles into MD_BUSY -> all outputs 0 while low; after release state=IDLE, HiLoBusy=0, mflo in ID proceeds with nop=1.
6. Hold a HiLo stall for 2^CNT_W+3 cycles using CNT_W=4 override and MD_LATENCY=15 repeated -> StallCycles saturates at 15, no wrap.
